// File: rtl/pipe_stage_skid_pkg.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Package : pipe_stage_skid_pkg                                            |
// | Purpose : Shared constants and types for the generic inter-stage         |
// |           pipeline register (pipe_stage_skid) and its link interface.    |
// | Contents: NOP_INST / ZERO_WORD empty-slot values, default widths, and    |
// |           the EX->MEM payload layout packed by the caller into the       |
// |           opaque data bus.                                               |
// | Macros  : none (BRANCH_PC_TRACK_EN is consumed by pipe_stage_skid).      |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

package pipe_stage_skid_pkg;

  // Default link widths.
  localparam int unsigned DEF_DATA_W = 160;
  localparam int unsigned DEF_PC_W   = 32;
  localparam int unsigned DEF_INST_W = 32;

  // Canonical RISC-V NOP (addi x0, x0, 0) shown on an empty stage.
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // EX->MEM payload layout. The stage treats it as opaque bits; the
  // producer and consumer agree on this packing. Total is DEF_DATA_W.
  typedef struct packed {
    logic [26:0] pad;
    logic [4:0]  exc_cause;
    logic        exc_valid;
    logic [31:0] alu_res;
    logic [7:0]  uop;
    logic [3:0]  mem_op;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic        rd_we;
    logic [4:0]  rd;
  } ex_mem_payload_t;

  // Bit offsets of the EX->MEM fields inside the payload bus.
  localparam int unsigned EXMEM_RD_LSB        = 0;
  localparam int unsigned EXMEM_RD_WE_LSB     = 5;
  localparam int unsigned EXMEM_CSR_ADDR_LSB  = 6;
  localparam int unsigned EXMEM_CSR_WE_LSB    = 18;
  localparam int unsigned EXMEM_MEM_ADDR_LSB  = 19;
  localparam int unsigned EXMEM_MEM_WDATA_LSB = 51;
  localparam int unsigned EXMEM_MEM_OP_LSB    = 83;
  localparam int unsigned EXMEM_UOP_LSB       = 87;
  localparam int unsigned EXMEM_ALU_RES_LSB   = 95;
  localparam int unsigned EXMEM_EXC_VALID_LSB = 127;
  localparam int unsigned EXMEM_EXC_CAUSE_LSB = 128;

  // Packs an EX->MEM record onto the raw payload bus.
  function automatic logic [DEF_DATA_W-1:0] pack_ex_mem(input ex_mem_payload_t p);
    return DEF_DATA_W'(p);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_skid_if.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Interface: pipe_stage_skid_if                                            |
// | Purpose  : One valid/ready pipeline link carrying payload, pc and inst,  |
// |            plus the branch-tracking side-band bits.                      |
// | Signals  : valid      producer holds a valid instruction                 |
// |            ready      consumer can accept                                |
// |            data       opaque payload  [DATA_W]                           |
// |            pc         instruction pc  [PC_W]                             |
// |            inst       instruction word [INST_W]                          |
// |            branch_tag taken branch/jump marker                           |
// |            branch_end first instruction from the branch target           |
// | Modports : master (producer side), slave (consumer side)                 |
// | Macros   : none                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned INST_W = DEF_INST_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic              branch_tag;
  logic              branch_end;

  modport master (
    output valid, data, pc, inst, branch_tag, branch_end,
    input  ready
  );

  modport slave (
    input  valid, data, pc, inst, branch_tag, branch_end,
    output ready
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage_skid_entry.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : pipe_skid_entry                                                |
// | Purpose : One {valid, data, pc, inst} storage slot with load and clear.  |
// |           A cleared slot holds the empty values (0 / 0 / NOP) so the     |
// |           owner can drive its outputs straight from the registers.       |
// | Ports   : clk_i    clock                                                 |
// |           rst_i    synchronous active-high reset                         |
// |           clr_i    invalidate the slot (wins over load_i)                |
// |           load_i   capture data_i/pc_i/inst_i and mark valid             |
// |           data_i, pc_i, inst_i   value to capture                        |
// |           valid_o, data_o, pc_o, inst_o   stored slot                    |
// | Macros  : none                                                           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module pipe_skid_entry
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned INST_W = DEF_INST_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [INST_W-1:0] inst_q,  inst_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (clr_i) begin
      valid_d = 1'b0;
      data_d  = '0;
      pc_d    = '0;
      inst_d  = INST_W'(NOP_INST);
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
      inst_q  <= INST_W'(NOP_INST);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : pipe_stage_skid                                                |
// | Purpose : Generic inter-stage pipeline register with valid/ready         |
// |           handshake and a 2-entry skid buffer (main + skid), so the      |
// |           upstream ready is a pure register output. Carries an opaque    |
// |           payload plus pc/inst; flush kills every held entry.            |
// | Ports   : clk_i    core clock                                            |
// |           rst_i    synchronous active-high reset                         |
// |           flush_i  drop all held entries this cycle                      |
// |           up_if    slave link from the upstream stage                    |
// |                    (valid/ready/data/pc/inst/branch_tag/branch_end)      |
// |           dn_if    master link to the downstream stage; branch side-band |
// |                    is driven low                                         |
// | Macros  : BRANCH_PC_TRACK_EN - when defined, entries accepted while a    |
// |           taken branch is being tracked record the branch pc instead of  |
// |           their own pc; when undefined the tracker is absent and the     |
// |           branch side-band inputs are ignored.                           |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned INST_W = DEF_INST_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  pipe_stage_skid_if.slave    up_if,
  pipe_stage_skid_if.master   dn_if
);

  // Slot state.
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data,  skid_data;
  logic [PC_W-1:0]   main_pc,    skid_pc;
  logic [INST_W-1:0] main_inst,  skid_inst;

  logic              in_ready_q, in_ready_d;

  // Handshake decode.
  logic              accept;      // input transfer happens this cycle
  logic              main_free;   // main is empty or being drained
  logic              out_fire;    // output transfer happens this cycle
  logic [PC_W-1:0]   in_pc;       // pc recorded for the incoming entry

  logic              main_load, main_clr, skid_load, skid_clr;
  logic [DATA_W-1:0] main_src_data;
  logic [PC_W-1:0]   main_src_pc;
  logic [INST_W-1:0] main_src_inst;
  logic              skid_valid_next;

  assign accept    = up_if.valid && in_ready_q && !flush_i;
  assign out_fire  = main_valid && dn_if.ready;
  assign main_free = !main_valid || dn_if.ready;

  // A queued skid entry always has priority for main; accept cannot coincide
  // with a valid skid because in_ready_q is low whenever skid is occupied.
  assign main_load = !flush_i && main_free && (skid_valid || accept);
  assign main_clr  = flush_i || (out_fire && !skid_valid && !accept);
  assign skid_load = !flush_i && accept && !main_free;
  assign skid_clr  = flush_i || (skid_valid && main_free);

  assign main_src_data = skid_valid ? skid_data : up_if.data;
  assign main_src_pc   = skid_valid ? skid_pc   : in_pc;
  assign main_src_inst = skid_valid ? skid_inst : up_if.inst;

  // Ready is the registered complement of next-cycle skid occupancy.
  assign skid_valid_next = skid_load || (skid_valid && !skid_clr);

  always_comb begin
    in_ready_d = !skid_valid_next;
    if (flush_i) begin
      in_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= in_ready_d;
    end
  end

`ifdef BRANCH_PC_TRACK_EN
  // While a taken branch is in flight, every accepted entry is stamped with
  // the branch pc until the first target-fetched instruction is accepted.
  logic            br_active_q, br_active_d;
  logic [PC_W-1:0] br_pc_q,     br_pc_d;

  always_comb begin
    br_active_d = br_active_q;
    br_pc_d     = br_pc_q;
    if (flush_i) begin
      br_active_d = 1'b0;
      br_pc_d     = '0;
    end else if (accept) begin
      // Tag is checked first so tag+end (self-loop) keeps the tracker alive.
      if (up_if.branch_tag) begin
        br_active_d = 1'b1;
        br_pc_d     = up_if.pc;
      end else if (br_active_q && up_if.branch_end) begin
        br_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_active_q <= 1'b0;
      br_pc_q     <= '0;
    end else begin
      br_active_q <= br_active_d;
      br_pc_q     <= br_pc_d;
    end
  end

  assign in_pc = br_active_q ? br_pc_q : up_if.pc;
`else
  logic unused_branch;
  assign unused_branch = up_if.branch_tag ^ up_if.branch_end;
  assign in_pc         = up_if.pc;
`endif

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .data_i  (main_src_data),
    .pc_i    (main_src_pc),
    .inst_i  (main_src_inst),
    .valid_o (main_valid),
    .data_o  (main_data),
    .pc_o    (main_pc),
    .inst_o  (main_inst)
  );

  pipe_skid_entry #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (skid_clr),
    .load_i  (skid_load),
    .data_i  (up_if.data),
    .pc_i    (in_pc),
    .inst_i  (up_if.inst),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  assign up_if.ready      = in_ready_q;
  assign dn_if.valid      = main_valid;
  assign dn_if.data       = main_data;
  assign dn_if.pc         = main_pc;
  assign dn_if.inst       = main_inst;
  assign dn_if.branch_tag = 1'b0;
  assign dn_if.branch_end = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module  : tb_pipe_stage_skid                                             |
// | Purpose : Self-checking bench for pipe_stage_skid: table-driven          |
// |           streaming/backpressure vectors, hand-written flush, reset and  |
// |           branch sequences, and randomized traffic against a queue-based |
// |           reference model.                                               |
// | Macros  : BRANCH_PC_TRACK_EN selects the expected pc behaviour.          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  localparam int unsigned DW = 160;
  localparam int unsigned PW = 32;
  localparam int unsigned IW = 32;
`ifdef BRANCH_PC_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .PC_W(PW), .INST_W(IW)) up_if ();
  pipe_stage_skid_if #(.DATA_W(DW), .PC_W(PW), .INST_W(IW)) dn_if ();

  pipe_stage_skid #(.DATA_W(DW), .PC_W(PW), .INST_W(IW)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .up_if   (up_if),
    .dn_if   (dn_if)
  );

  // Reference model: FIFO of held entries (capacity 2) plus branch tracker.
  typedef struct {
    logic [DW-1:0] data;
    logic [PW-1:0] pc;
    logic [IW-1:0] inst;
  } ent_t;

  ent_t          mq[$];
  logic          m_br_act = 1'b0;
  logic [PW-1:0] m_br_pc  = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    bit          iv;
    bit          ordy;
    logic [31:0] pc;
    bit          exp_v;
    bit          exp_rdy;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [DW-1:0] mk_data(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h5A5A_5A5A, pc + 32'd7, pc | 32'hC0DE_0000};
  endfunction

  function automatic logic [IW-1:0] mk_inst(input logic [31:0] pc);
    return (pc << 12) | 32'h0000_0033;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input bit iv, input logic [31:0] pc, input bit tag, input bit en,
                       input bit ordy, input bit fl);
    up_if.valid      = iv;
    up_if.pc         = pc;
    up_if.data       = mk_data(pc);
    up_if.inst       = mk_inst(pc);
    up_if.branch_tag = tag;
    up_if.branch_end = en;
    dn_if.ready      = ordy;
    flush            = fl;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    ent_t e;
    bit   can_in;
    bit   pop;
    if (rst || flush) begin
      mq.delete();
      m_br_act = 1'b0;
      m_br_pc  = '0;
    end else begin
      can_in = (mq.size() < 2);
      pop    = (mq.size() > 0) && dn_if.ready;
      if (pop) void'(mq.pop_front());
      if (up_if.valid && can_in) begin
        e.data = up_if.data;
        e.inst = up_if.inst;
        e.pc   = (TRACK && m_br_act) ? m_br_pc : up_if.pc;
        mq.push_back(e);
        if (TRACK) begin
          if (up_if.branch_tag) begin
            m_br_act = 1'b1;
            m_br_pc  = up_if.pc;
          end else if (m_br_act && up_if.branch_end) begin
            m_br_act = 1'b0;
          end
        end
      end
    end
  endtask

  // One clock: update model, let the DUT clock, compare after the edge.
  task automatic step();
    logic [DW-1:0] ed;
    logic [PW-1:0] ep;
    logic [IW-1:0] ei;
    model_edge();
    @(posedge clk);
    #1;
    if (mq.size() > 0) begin
      ed = mq[0].data; ep = mq[0].pc; ei = mq[0].inst;
    end else begin
      ed = '0; ep = '0; ei = NOP_INST;
    end
    check("mdl_out_valid", DW'(dn_if.valid), DW'(mq.size() != 0));
    check("mdl_in_ready",  DW'(up_if.ready), DW'(mq.size() < 2));
    check("mdl_data",      dn_if.data, ed);
    check("mdl_pc",        DW'(dn_if.pc), DW'(ep));
    check("mdl_inst",      DW'(dn_if.inst), DW'(ei));
  endtask

  initial begin
    // Streaming: 8 back-to-back, then drain.
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b1, 32'h100 + 32'(4 * i)});
    tbl.push_back('{1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h0});
    // Backpressure: A accepted, B into skid, C refused, then release.
    tbl.push_back('{1'b1, 1'b1, 32'h120, 1'b1, 1'b1, 32'h120});
    tbl.push_back('{1'b1, 1'b0, 32'h124, 1'b1, 1'b0, 32'h120});
    tbl.push_back('{1'b1, 1'b0, 32'h128, 1'b1, 1'b0, 32'h120});
    tbl.push_back('{1'b1, 1'b1, 32'h128, 1'b1, 1'b1, 32'h124});
    tbl.push_back('{1'b1, 1'b1, 32'h128, 1'b1, 1'b1, 32'h128});
    tbl.push_back('{1'b0, 1'b1, 32'h0,   1'b0, 1'b1, 32'h0});

    // Reset.
    drive(0, 32'h0, 0, 0, 1, 0);
    rst = 1'b1;
    step();
    step();
    check("rst_out_valid", DW'(dn_if.valid), DW'(0));
    check("rst_in_ready",  DW'(up_if.ready), DW'(1));
    check("rst_inst",      DW'(dn_if.inst), DW'(NOP_INST));
    rst = 1'b0;

    // Table-driven vectors.
    foreach (tbl[i]) begin
      drive(tbl[i].iv, tbl[i].pc, 0, 0, tbl[i].ordy, 0);
      step();
      check($sformatf("tbl%0d_valid", i), DW'(dn_if.valid), DW'(tbl[i].exp_v));
      check($sformatf("tbl%0d_ready", i), DW'(up_if.ready), DW'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_pc", i),    DW'(dn_if.pc), DW'(tbl[i].exp_pc));
      check($sformatf("tbl%0d_inst", i),  DW'(dn_if.inst),
            DW'(tbl[i].exp_v ? mk_inst(tbl[i].exp_pc) : NOP_INST));
    end

    // Flush with main and skid full and an input offered.
    drive(1, 32'h400, 0, 0, 0, 0); step();
    drive(1, 32'h404, 0, 0, 0, 0); step();
    check("fl_full_ready", DW'(up_if.ready), DW'(0));
    drive(1, 32'h408, 0, 0, 0, 1); step();
    check("fl_valid", DW'(dn_if.valid), DW'(0));
    check("fl_inst",  DW'(dn_if.inst), DW'(NOP_INST));
    check("fl_ready", DW'(up_if.ready), DW'(1));
    check("fl_data",  dn_if.data, '0);
    drive(0, 32'h0, 0, 0, 1, 0); step();
    check("fl_no_ghost", DW'(dn_if.valid), DW'(0));
    // Flush while ready: offered input is dropped.
    drive(1, 32'h40C, 0, 0, 1, 1); step();
    drive(0, 32'h0, 0, 0, 1, 0); step();
    check("fl_drop_valid", DW'(dn_if.valid), DW'(0));

    // Reset mid-stream with both entries full (tracker armed first).
    drive(1, 32'h4F0, 1, 0, 0, 0); step();
    drive(1, 32'h4F4, 0, 0, 0, 0); step();
    rst = 1'b1;
    drive(1, 32'h4F8, 0, 0, 0, 0); step();
    check("rm_valid", DW'(dn_if.valid), DW'(0));
    check("rm_ready", DW'(up_if.ready), DW'(1));
    check("rm_pc",    DW'(dn_if.pc), DW'(0));
    check("rm_inst",  DW'(dn_if.inst), DW'(NOP_INST));
    rst = 1'b0;
    drive(1, 32'h500, 0, 0, 1, 0); step();
    check("rm_post_valid", DW'(dn_if.valid), DW'(1));
    check("rm_post_pc",    DW'(dn_if.pc), DW'(32'h500));
    drive(0, 32'h0, 0, 0, 1, 0); step();

    // Branch tracking sequence.
    drive(1, 32'h200, 1, 0, 1, 0); step();
    check("br_pc0", DW'(dn_if.pc), DW'(32'h200));
    drive(1, 32'h204, 0, 0, 1, 0); step();
    check("br_pc1", DW'(dn_if.pc), DW'(TRACK ? 32'h200 : 32'h204));
    drive(1, 32'h208, 0, 1, 1, 0); step();
    check("br_pc2", DW'(dn_if.pc), DW'(TRACK ? 32'h200 : 32'h208));
    drive(1, 32'h20C, 0, 0, 1, 0); step();
    check("br_pc3", DW'(dn_if.pc), DW'(32'h20C));
    drive(0, 32'h0, 0, 0, 1, 0); step();

    // Self-loop: tag+end keeps the tracker active; flush clears it.
    drive(1, 32'h300, 1, 1, 1, 0); step();
    check("sl_pc0", DW'(dn_if.pc), DW'(32'h300));
    drive(1, 32'h300, 1, 1, 1, 0); step();
    check("sl_pc1", DW'(dn_if.pc), DW'(32'h300));
    drive(1, 32'h304, 0, 0, 1, 0); step();
    check("sl_pc2", DW'(dn_if.pc), DW'(TRACK ? 32'h300 : 32'h304));
    drive(0, 32'h0, 0, 0, 1, 1); step();
    drive(1, 32'h308, 0, 0, 1, 0); step();
    check("sl_after_flush", DW'(dn_if.pc), DW'(32'h308));
    drive(0, 32'h0, 0, 0, 1, 0); step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      rst = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
